// File: rtl/control_unit_if.sv
// ============================================================================
// Module   : control_unit_if
// Brief    : Instruction-ROM and datapath-control bundle of the control unit.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface control_unit_if #(
    parameter int PC_W = 7
);
    logic [PC_W-1:0] IM_Addr;
    logic [15:0]     IM_Data;
    logic [7:0]      DAddr;
    logic            DWrite;
    logic            RFSelect;
    logic [3:0]      WriteAddr;
    logic            RFWriteEnable;
    logic [3:0]      ReadAddrA;
    logic [3:0]      ReadAddrB;
    logic [2:0]      ALUSelect;
    logic [3:0]      State;
    logic            Halted;

    modport master (
        output IM_Addr, DAddr, DWrite, RFSelect, WriteAddr, RFWriteEnable,
               ReadAddrA, ReadAddrB, ALUSelect, State, Halted,
        input  IM_Data
    );

    modport slave (
        input  IM_Addr, DAddr, DWrite, RFSelect, WriteAddr, RFWriteEnable,
               ReadAddrA, ReadAddrB, ALUSelect, State, Halted,
        output IM_Data
    );
endinterface

`default_nettype wire

// File: rtl/control_unit.sv
// ============================================================================
// Module   : control_unit
// Brief    : PC/IR holder and Moore fetch-decode-execute sequencer for the
//            datapath. Optional single-step gating via CONTROL_UNIT_STEP_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module control_unit #(
    parameter int       PC_W    = 7,
    parameter bit [2:0] ALU_ADD = 3'b001,
    parameter bit [2:0] ALU_SUB = 3'b010
) (
    input  wire logic         Clk,
    input  wire logic         Reset,
`ifdef CONTROL_UNIT_STEP_EN
    input  wire logic         Step,
`endif
    control_unit_if.master    bus
);

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_LOAD_A = 4'd3,
        S_LOAD_B = 4'd4,
        S_STORE  = 4'd5,
        S_ADD    = 4'd6,
        S_SUB    = 4'd7,
        S_HALT   = 4'd8,
        S_NOOP   = 4'd9
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [PC_W-1:0] r_pc;
    // Opcode is decoded straight from ROM data, so only the operand field is kept.
    logic [11:0]     r_ir;
    logic            w_fetch_go;

    logic [7:0]      w_daddr;
    logic            w_dwrite;
    logic            w_rfselect;
    logic [3:0]      w_waddr;
    logic            w_rfwe;
    logic [3:0]      w_raddr_a;
    logic [3:0]      w_raddr_b;
    logic [2:0]      w_alusel;
    logic            w_halted;

`ifdef CONTROL_UNIT_STEP_EN
    logic r_step_prev;

    always_ff @(posedge Clk) begin
        if (Reset) r_step_prev <= 1'b0;
        else       r_step_prev <= Step;
    end

    // Edges outside FETCH are simply lost because r_step_prev tracks every cycle.
    assign w_fetch_go = Step & ~r_step_prev;
`else
    assign w_fetch_go = 1'b1;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= S_INIT;
            r_pc    <= '0;
            r_ir    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_FETCH && w_fetch_go) r_pc <= r_pc + 1'b1;
            if (r_state == S_DECODE)              r_ir <= bus.IM_Data[11:0];
        end
    end

    always_comb begin
        w_next     = r_state;
        w_daddr    = 8'h00;
        w_dwrite   = 1'b0;
        w_rfselect = 1'b0;
        w_waddr    = 4'h0;
        w_rfwe     = 1'b0;
        w_raddr_a  = 4'h0;
        w_raddr_b  = 4'h0;
        w_alusel   = 3'b000;
        w_halted   = 1'b0;
        case (r_state)
            S_INIT:   w_next = S_FETCH;
            S_FETCH:  if (w_fetch_go) w_next = S_DECODE;
            S_DECODE: begin
                case (bus.IM_Data[15:12])
                    4'h1:    w_next = S_STORE;
                    4'h2:    w_next = S_LOAD_A;
                    4'h3:    w_next = S_ADD;
                    4'h4:    w_next = S_SUB;
                    4'h5:    w_next = S_HALT;
                    default: w_next = S_NOOP;
                endcase
            end
            S_LOAD_A, S_LOAD_B: begin
                w_daddr    = r_ir[11:4];
                w_rfselect = 1'b1;
                w_waddr    = r_ir[3:0];
                // LOAD_A only waits out the data-RAM read latency.
                w_rfwe     = (r_state == S_LOAD_B);
                w_next     = (r_state == S_LOAD_A) ? S_LOAD_B : S_FETCH;
            end
            S_STORE: begin
                w_raddr_a = r_ir[11:8];
                w_daddr   = r_ir[7:0];
                w_dwrite  = 1'b1;
                w_next    = S_FETCH;
            end
            S_ADD, S_SUB: begin
                w_raddr_a = r_ir[11:8];
                w_raddr_b = r_ir[7:4];
                w_waddr   = r_ir[3:0];
                w_rfwe    = 1'b1;
                w_alusel  = (r_state == S_ADD) ? ALU_ADD : ALU_SUB;
                w_next    = S_FETCH;
            end
            S_NOOP:   w_next = S_FETCH;
            S_HALT:   w_halted = 1'b1;
            default:  w_next = S_INIT;
        endcase
    end

    assign bus.IM_Addr       = r_pc;
    assign bus.DAddr         = w_daddr;
    assign bus.DWrite        = w_dwrite;
    assign bus.RFSelect      = w_rfselect;
    assign bus.WriteAddr     = w_waddr;
    assign bus.RFWriteEnable = w_rfwe;
    assign bus.ReadAddrA     = w_raddr_a;
    assign bus.ReadAddrB     = w_raddr_b;
    assign bus.ALUSelect     = w_alusel;
    assign bus.State         = r_state;
    assign bus.Halted        = w_halted;

endmodule

`default_nettype wire

// File: tb/tb_control_unit.sv
// ============================================================================
// Module   : tb_control_unit
// Brief    : Scoreboard bench: per-cycle expected control vectors are queued
//            per instruction and compared against the DUT every cycle.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_control_unit;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [15:0] rom [128];
    logic [15:0] rom_q;
`ifdef CONTROL_UNIT_STEP_EN
    logic        step = 1'b0;
`endif

    control_unit_if bus ();

    control_unit dut (
        .Clk   (Clk),
        .Reset (Reset),
`ifdef CONTROL_UNIT_STEP_EN
        .Step  (step),
`endif
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) rom_q <= rom[bus.IM_Addr];
    assign bus.IM_Data = rom_q;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    logic [37:0] q [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs === exp) passed++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // {State, IM_Addr, DAddr, DWrite, RFSelect, WriteAddr, RFWE, RA, RB, ALU, Halted}
    function automatic logic [37:0] ev(input logic [3:0] st, input logic [6:0] im,
                                       input logic [7:0] da, input logic dw, input logic rfs,
                                       input logic [3:0] wa, input logic we,
                                       input logic [3:0] ra, input logic [3:0] rb,
                                       input logic [2:0] alu, input logic h);
        return {st, im, da, dw, rfs, wa, we, ra, rb, alu, h};
    endfunction

    function automatic logic [37:0] observed();
        return {bus.State, bus.IM_Addr, bus.DAddr, bus.DWrite, bus.RFSelect, bus.WriteAddr,
                bus.RFWriteEnable, bus.ReadAddrA, bus.ReadAddrB, bus.ALUSelect, bus.Halted};
    endfunction

    task automatic push_init();
        q.push_back(ev(4'd0, 7'd0, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'b000, 0));
    endtask

    task automatic push_instr(input logic [6:0] pc, input logic [15:0] ir, input int halt_cycles);
        logic [6:0] n;
        n = pc + 7'd1;
        q.push_back(ev(4'd1, pc, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'b000, 0));
        q.push_back(ev(4'd2, n,  8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'b000, 0));
        case (ir[15:12])
            4'h1: q.push_back(ev(4'd5, n, ir[7:0], 1, 0, 4'h0, 0, ir[11:8], 4'h0, 3'b000, 0));
            4'h2: begin
                q.push_back(ev(4'd3, n, ir[11:4], 0, 1, ir[3:0], 0, 4'h0, 4'h0, 3'b000, 0));
                q.push_back(ev(4'd4, n, ir[11:4], 0, 1, ir[3:0], 1, 4'h0, 4'h0, 3'b000, 0));
            end
            4'h3: q.push_back(ev(4'd6, n, 8'h00, 0, 0, ir[3:0], 1, ir[11:8], ir[7:4], 3'b001, 0));
            4'h4: q.push_back(ev(4'd7, n, 8'h00, 0, 0, ir[3:0], 1, ir[11:8], ir[7:4], 3'b010, 0));
            4'h5: for (int i = 0; i < halt_cycles; i++)
                      q.push_back(ev(4'd8, n, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'b000, 1));
            default: q.push_back(ev(4'd9, n, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'b000, 0));
        endcase
    endtask

    task automatic tick();
        logic [37:0] e;
        @(posedge Clk);
        #1;
        cyc++;
        if (q.size() == 0) begin
            check("scoreboard_empty", 64'd1, 64'd0);
        end else begin
            e = q.pop_front();
            check($sformatf("cyc%0d", cyc), 64'(observed()), 64'(e));
        end
    endtask

    task automatic drain();
        while (q.size() > 0) tick();
    endtask

    initial begin
        Reset = 1'b1;
        for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
        rom[0] = 16'h2003;
        rom[1] = 16'h3124;
        rom[2] = 16'h1409;
        rom[3] = 16'h4125;
        rom[4] = 16'hF000;
        rom[5] = 16'h0000;
        rom[6] = 16'h5000;
        rom[7] = 16'h3124;

        // Reset held two cycles, then the main program runs into HALT.
        push_init(); tick();
        push_init(); tick();
        Reset = 1'b0;
        for (int i = 0; i < 6; i++) push_instr(7'(i), rom[i], 0);
        push_instr(7'd6, rom[6], 25);
        drain();

        // Reset out of HALT returns to INIT with PC=0.
        Reset = 1'b1;
        push_init(); tick();
        Reset = 1'b0;

        // Reset asserted during LOAD_A: next edge is INIT, LOAD_B never appears.
        q.push_back(ev(4'd1, 7'd0, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'b000, 0));
        q.push_back(ev(4'd2, 7'd1, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'b000, 0));
        q.push_back(ev(4'd3, 7'd1, 8'h00, 0, 1, 4'h3, 0, 4'h0, 4'h0, 3'b000, 0));
        drain();
        Reset = 1'b1;
        push_init(); tick();

        // PC wrap: NOOPs through 126, unknown opcode at 127, then fetch from 0 again.
        for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
        rom[127] = 16'hF000;
        push_init(); tick();
        Reset = 1'b0;
        for (int i = 0; i < 128; i++) push_instr(7'(i), rom[i], 0);
        push_instr(7'd0, rom[0], 0);
        drain();

        Reset = 1'b1;
        push_init(); tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
